// File: rtl/pc_branch_unit.sv
// pc_branch_unit: owns the fetch PC, redirects on a taken branch and squashes IF/ID + ID/EX for a fixed window.
// Optional branch/taken statistics counters are built when BRANCH_STATS_EN is defined.
module pc_branch_unit #(
   parameter int unsigned          WORD_LEN     = 32,
   parameter logic [WORD_LEN-1:0]  RESET_PC     = '0,
   parameter int unsigned          INSTR_BYTES  = 4,
   parameter int unsigned          FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                brValid,
   input  logic                brCond,
   input  logic [WORD_LEN-1:0] brTarget,
`ifdef BRANCH_STATS_EN
   input  logic                statClr,
   output logic [15:0]         brCount,
   output logic [15:0]         takenCount,
`endif
   output logic [WORD_LEN-1:0] pc,
   output logic                redirect,
   output logic                flushIfId,
   output logic                flushIdEx,
   output logic                brMisalign
);

   localparam int unsigned        CNT_W      = 3;
   localparam logic [WORD_LEN-1:0] ALIGN_MASK = WORD_LEN'(INSTR_BYTES - 1);
   localparam logic [WORD_LEN-1:0] PC_INC     = WORD_LEN'(INSTR_BYTES);

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_accept;
   logic               w_take;
   logic [WORD_LEN-1:0] w_pc_inc;
   logic [WORD_LEN-1:0] w_aligned;
   logic               w_misalign;

   // A resolved branch only counts while fetching the correct path
   assign w_accept   = brValid & (r_state == S_RUN);
   assign w_take     = w_accept & brCond;
   assign w_pc_inc   = pc + PC_INC;
   assign w_aligned  = brTarget & ~ALIGN_MASK;
   assign w_misalign = |(brTarget & ALIGN_MASK);

   // PC / redirect FSM; flush lines mirror the FLUSH window one cycle after the taking edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_RUN;
         r_cnt      <= '0;
         pc         <= RESET_PC;
         redirect   <= 1'b0;
         flushIfId  <= 1'b0;
         flushIdEx  <= 1'b0;
         brMisalign <= 1'b0;
      end else begin
         redirect   <= 1'b0;
         brMisalign <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (w_take) begin
                  pc         <= w_aligned;
                  r_state    <= S_FLUSH;
                  r_cnt      <= CNT_W'(FLUSH_CYCLES);
                  redirect   <= 1'b1;
                  brMisalign <= w_misalign;
                  flushIfId  <= 1'b1;
                  flushIdEx  <= 1'b1;
               end else if (!stall) begin
                  pc <= w_pc_inc;
               end
            end
            S_FLUSH: begin
               pc    <= w_pc_inc;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state   <= S_RUN;
                  flushIfId <= 1'b0;
                  flushIdEx <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_RUN;
               flushIfId <= 1'b0;
               flushIdEx <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   localparam logic [15:0] STAT_MAX = 16'hFFFF;

   // Saturating statistics; clear has priority over counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brCount    <= '0;
         takenCount <= '0;
      end else if (statClr) begin
         brCount    <= '0;
         takenCount <= '0;
      end else begin
         if (w_accept && (brCount != STAT_MAX))
            brCount <= brCount + 16'd1;
         if (w_take && (takenCount != STAT_MAX))
            takenCount <= takenCount + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a driver feeds directed and random branch traffic into a
// behavioural model that queues expected outputs; a monitor pops and compares after every clock edge.
module tb_pc_branch_unit;

   localparam int unsigned FC = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, brValid, brCond, statClr;
   logic [31:0] brTarget;
   logic [31:0] pc;
   logic        redirect, flushIfId, flushIdEx, brMisalign;
   logic [15:0] brCount, takenCount;

   typedef struct {
      logic [31:0] pc;
      logic        rd;
      logic        fl;
      logic        mis;
      logic [15:0] bc;
      logic [15:0] tc;
   } exp_t;

   exp_t q[$];

   int checks   = 0;
   int failures = 0;

   // Model state: where fetch is, and how many upcoming cycles are still being squashed
   logic [31:0] m_pc;
   int          m_left;
   logic [15:0] m_bc, m_tc;

   pc_branch_unit #(
      .WORD_LEN(32), .RESET_PC(32'h0), .INSTR_BYTES(4), .FLUSH_CYCLES(FC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .brValid(brValid), .brCond(brCond),
      .brTarget(brTarget),
`ifdef BRANCH_STATS_EN
      .statClr(statClr), .brCount(brCount), .takenCount(takenCount),
`endif
      .pc(pc), .redirect(redirect), .flushIfId(flushIfId), .flushIdEx(flushIdEx),
      .brMisalign(brMisalign)
   );

`ifndef BRANCH_STATS_EN
   assign brCount    = 16'h0;
   assign takenCount = 16'h0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc   = 32'h0;
      m_left = 0;
      m_bc   = 16'h0;
      m_tc   = 16'h0;
   endtask

   // Drive one cycle (caller is in the low phase), predict the post-edge outputs, wait for next negedge
   task automatic step(input logic s, input logic bv, input logic bc, input logic [31:0] tgt,
                       input logic clr);
      exp_t e;
      stall = s; brValid = bv; brCond = bc; brTarget = tgt; statClr = clr;
      e.rd  = 1'b0;
      e.mis = 1'b0;
      if (m_left > 0) begin
         m_left--;
         m_pc = m_pc + 32'd4;
      end else begin
         if (bv && !clr && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
         if (bv && bc) begin
            m_pc   = tgt - (tgt % 32'd4);
            e.rd   = 1'b1;
            e.mis  = (tgt % 32'd4) != 0;
            m_left = FC;
            if (!clr && m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
         end else if (!s) begin
            m_pc = m_pc + 32'd4;
         end
      end
      if (clr) begin
         m_bc = 16'h0;
         m_tc = 16'h0;
      end
      e.pc = m_pc;
      e.fl = (m_left > 0);
      e.bc = m_bc;
      e.tc = m_tc;
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: one expected entry per clock edge while traffic is queued
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pc", pc, e.pc);
            check("redirect", 32'(redirect), 32'(e.rd));
            check("flushIfId", 32'(flushIfId), 32'(e.fl));
            check("flushIdEx", 32'(flushIdEx), 32'(e.fl));
            check("brMisalign", 32'(brMisalign), 32'(e.mis));
`ifdef BRANCH_STATS_EN
            check("brCount", 32'(brCount), 32'(e.bc));
            check("takenCount", 32'(takenCount), 32'(e.tc));
`endif
         end
      end
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; brValid = 1'b0; brCond = 1'b0; brTarget = '0; statClr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", pc, 32'h0);
      check("reset_redirect", 32'(redirect), 32'h0);
      check("reset_flush", 32'({flushIfId, flushIdEx}), 32'h0);
      check("reset_misalign", 32'(brMisalign), 32'h0);
      check("reset_stats", {brCount, takenCount}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential fetch, then the documented taken branch from 0x10 to 0x80
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      // Not taken, stall hold, take-with-stall to a misaligned target, branch during flush
      step(1'b0, 1'b1, 1'b0, 32'h500, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h103, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h700, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h900, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      // Wraparound at the top of the address space
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      // Back-to-back: branch on the first RUN cycle after a flush window
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h1002, 1'b0);

      // Asynchronous reset in the middle of a flush window
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midflush_rst_flushIfId", 32'(flushIfId), 32'h0);
      check("midflush_rst_flushIdEx", 32'(flushIdEx), 32'h0);
      check("midflush_rst_pc", pc, 32'h0);
      model_reset();
      #1;
      rst_n = 1'b1;

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) == 0, ($urandom % 2) == 1, ($urandom % 2) == 1, $urandom,
              ($urandom % 50) == 0);
      end

`ifdef BRANCH_STATS_EN
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h20, 1'b1);
`endif
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
